// File: rtl/coin_payout_if.sv
// rtl/coin_payout_if.sv - change request valid/ready handshake
interface coin_payout_if #(
    parameter int AMT_W = 8
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;

    modport master (output req_valid, output req_amount, input req_ready);
    modport slave  (input req_valid, input req_amount, output req_ready);
endinterface

// File: rtl/coin_payout.sv
// rtl/coin_payout.sv - largest-coin-first change payout with per-denomination stock
module coin_payout #(
    parameter int AMT_W    = 8,
    parameter int STOCK_W  = 8,
    parameter int STOCK500 = 4,
    parameter int STOCK200 = 4,
    parameter int STOCK100 = 4,
    parameter int GAP      = 1
) (
    input  logic               clk,
    input  logic               reset,
    coin_payout_if.slave       req,
    input  logic               refill,
    output logic               Out500,
    output logic               Out200,
    output logic               Out100,
    output logic               busy,
    output logic               done,
    output logic               short,
    output logic [AMT_W-1:0]   remain,
    output logic [STOCK_W-1:0] stock500,
    output logic [STOCK_W-1:0] stock200,
    output logic [STOCK_W-1:0] stock100
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAPW, DONE} state_t;
    typedef enum logic [1:0] {C_NONE, C100, C200, C500} coin_t;

    state_t             state, state_n;
    coin_t              coin, coin_n;
    logic [AMT_W-1:0]   rem, rem_n;
    logic [GW-1:0]      gapcnt, gapcnt_n;
    logic [STOCK_W-1:0] s500_n, s200_n, s100_n;
    logic               short_n;
    logic [AMT_W-1:0]   remain_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            coin     <= C_NONE;
            rem      <= '0;
            gapcnt   <= '0;
            stock500 <= STOCK_W'(STOCK500);
            stock200 <= STOCK_W'(STOCK200);
            stock100 <= STOCK_W'(STOCK100);
            short    <= 1'b0;
            remain   <= '0;
        end else begin
            state    <= state_n;
            coin     <= coin_n;
            rem      <= rem_n;
            gapcnt   <= gapcnt_n;
            stock500 <= s500_n;
            stock200 <= s200_n;
            stock100 <= s100_n;
            short    <= short_n;
            remain   <= remain_n;
        end
    end

    assign req.req_ready = reset && (state == IDLE);

    always_comb begin
        state_n  = state;
        coin_n   = coin;
        rem_n    = rem;
        gapcnt_n = gapcnt;
        s500_n   = stock500;
        s200_n   = stock200;
        s100_n   = stock100;
        short_n  = short;
        remain_n = remain;
        Out500   = 1'b0;
        Out200   = 1'b0;
        Out100   = 1'b0;
        busy     = (state != IDLE);
        done     = (state == DONE);

        case (state)
            IDLE: begin
                // Refill lands first so a request accepted on the same edge sees full stock.
                if (refill) begin
                    s500_n = STOCK_W'(STOCK500);
                    s200_n = STOCK_W'(STOCK200);
                    s100_n = STOCK_W'(STOCK100);
                end
                if (req.req_valid) begin
                    rem_n    = req.req_amount;
                    short_n  = 1'b0;
                    remain_n = '0;
                    state_n  = (req.req_amount == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if (rem >= AMT_W'(5) && stock500 != '0) begin
                    coin_n  = C500;
                    state_n = PULSE;
                end else if (rem >= AMT_W'(2) && stock200 != '0) begin
                    coin_n  = C200;
                    state_n = PULSE;
                end else if (rem >= AMT_W'(1) && stock100 != '0) begin
                    coin_n  = C100;
                    state_n = PULSE;
                end else begin
                    short_n  = 1'b1;
                    remain_n = rem;
                    state_n  = DONE;
                end
            end
            PULSE: begin
                Out500   = (coin == C500);
                Out200   = (coin == C200);
                Out100   = (coin == C100);
                gapcnt_n = '0;
                state_n  = GAPW;
                // SELECT guaranteed rem >= value and stock > 0, so neither can wrap.
                case (coin)
                    C500: begin rem_n = rem - AMT_W'(5); s500_n = stock500 - STOCK_W'(1); end
                    C200: begin rem_n = rem - AMT_W'(2); s200_n = stock200 - STOCK_W'(1); end
                    C100: begin rem_n = rem - AMT_W'(1); s100_n = stock100 - STOCK_W'(1); end
                    default: ;
                endcase
            end
            GAPW: begin
                if (gapcnt == GW'(GAP - 1)) begin
                    state_n = (rem == '0) ? DONE : SELECT;
                end else begin
                    gapcnt_n = gapcnt + GW'(1);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coin_payout.sv
// tb/tb_coin_payout.sv - randomized and directed bench for coin_payout against a cycle-schedule model
module tb_coin_payout;
    localparam int AMT_W = 8, STOCK_W = 8, S5 = 4, S2 = 4, S1 = 4, GAP = 1;
    localparam int P = 2 + GAP;

    logic clk = 1'b0, reset = 1'b0, refill = 1'b0;
    logic Out500, Out200, Out100, busy, done, short;
    logic [AMT_W-1:0]   remain;
    logic [STOCK_W-1:0] stock500, stock200, stock100;

    coin_payout_if #(.AMT_W(AMT_W)) rq();

    coin_payout #(
        .AMT_W(AMT_W), .STOCK_W(STOCK_W), .STOCK500(S5), .STOCK200(S2),
        .STOCK100(S1), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .req(rq), .refill(refill),
        .Out500(Out500), .Out200(Out200), .Out100(Out100),
        .busy(busy), .done(done), .short(short), .remain(remain),
        .stock500(stock500), .stock200(stock200), .stock100(stock100)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit idle, o5, o2, o1, dn, sh;
        int rm, s5, s2, s1;
    } vec_t;

    vec_t cur;
    vec_t sched[$];
    int   m5 = S5, m2 = S2, m1 = S1, mrm = 0;
    bit   msh = 0, checking = 0;
    int   nchecks = 0, nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Greedy as plain arithmetic: all 500s first, then 200s, then 100s, each capped by stock.
    function automatic void greedy(input int amt, input int s5, input int s2, input int s1,
                                   output int n5, output int n2, output int n1, output int r);
        r  = amt;
        n5 = (r / 5 < s5) ? r / 5 : s5;  r -= 5 * n5;
        n2 = (r / 2 < s2) ? r / 2 : s2;  r -= 2 * n2;
        n1 = (r < s1) ? r : s1;          r -= n1;
    endfunction

    function automatic vec_t idle_vec();
        vec_t v = '{default: 0};
        v.idle = 1; v.s5 = m5; v.s2 = m2; v.s1 = m1; v.sh = msh; v.rm = mrm;
        return v;
    endfunction

    function automatic void build(input int amt);
        int n5, n2, n1, r, n, t, val;
        bit sf;
        vec_t v;
        greedy(amt, m5, m2, m1, n5, n2, n1, r);
        n  = n5 + n2 + n1;
        sf = (r > 0);
        t  = sf ? 2 + n * P : 1 + n * P;
        for (int k = 1; k <= t; k++) begin
            v = '{default: 0};
            v.s5 = m5; v.s2 = m2; v.s1 = m1;
            for (int j = 0; j < n; j++) begin
                val = (j < n5) ? 5 : (j < n5 + n2) ? 2 : 1;
                if (k == 2 + j * P) begin
                    if (val == 5) v.o5 = 1; else if (val == 2) v.o2 = 1; else v.o1 = 1;
                end
                if (k >= 3 + j * P) begin
                    if (val == 5) v.s5--; else if (val == 2) v.s2--; else v.s1--;
                end
            end
            v.dn = (k == t);
            v.sh = (k == t) && sf;
            v.rm = (k == t && sf) ? r : 0;
            sched.push_back(v);
        end
        m5 -= n5; m2 -= n2; m1 -= n1;
        msh = sf; mrm = sf ? r : 0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            sched.delete();
            m5 = S5; m2 = S2; m1 = S1; msh = 0; mrm = 0;
            cur = idle_vec();
            checking = 1;
        end else if (cur.idle) begin
            if (refill) begin m5 = S5; m2 = S2; m1 = S1; end
            if (rq.req_valid) begin
                build(int'(rq.req_amount));
                cur = sched.pop_front();
            end else begin
                cur = idle_vec();
            end
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else begin
            cur = idle_vec();
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("cmp_out500",   int'(Out500),       int'(cur.o5));
            chk("cmp_out200",   int'(Out200),       int'(cur.o2));
            chk("cmp_out100",   int'(Out100),       int'(cur.o1));
            chk("cmp_busy",     int'(busy),         int'(!cur.idle));
            chk("cmp_done",     int'(done),         int'(cur.dn));
            chk("cmp_ready",    int'(rq.req_ready), int'(cur.idle && reset));
            chk("cmp_short",    int'(short),        int'(cur.sh));
            chk("cmp_remain",   int'(remain),       cur.rm);
            chk("cmp_stock500", int'(stock500),     cur.s5);
            chk("cmp_stock200", int'(stock200),     cur.s2);
            chk("cmp_stock100", int'(stock100),     cur.s1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input int amt, input bit rf, input int busy_refill_at,
                           output int f5, output int f2, output int f1,
                           output int c5, output int c2, output int c1, output int dc);
        rq.req_valid = 1'b1; rq.req_amount = AMT_W'(amt); refill = rf;
        tick();
        rq.req_valid = 1'b0; refill = 1'b0;
        f5 = -1; f2 = -1; f1 = -1; c5 = 0; c2 = 0; c1 = 0; dc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (Out500) begin c5++; if (f5 < 0) f5 = k; end
            if (Out200) begin c2++; if (f2 < 0) f2 = k; end
            if (Out100) begin c1++; if (f1 < 0) f1 = k; end
            refill = (k == busy_refill_at);
            if (done) begin dc = k; break; end
        end
        refill = 1'b0;
        if (dc < 0) chk("req_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int n5, n2, n1, r, f5, f2, f1, c5, c2, c1, dc, nd;
        rq.req_valid = 1'b0; rq.req_amount = '0; refill = 1'b0; reset = 1'b0;

        greedy(8, 4, 4, 4, n5, n2, n1, r);
        chk("model_8_n5", n5, 1); chk("model_8_n2", n2, 1); chk("model_8_n1", n1, 1); chk("model_8_r", r, 0);
        greedy(30, 4, 4, 4, n5, n2, n1, r);
        chk("model_30_n5", n5, 4); chk("model_30_n2", n2, 4); chk("model_30_n1", n1, 2);
        greedy(5, 0, 0, 2, n5, n2, n1, r);
        chk("model_5_n1", n1, 2); chk("model_5_r", r, 3);

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(rq.req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({Out500, Out200, Out100, done, short}), 0);
        chk("rst_remain", int'(remain), 0);
        chk("rst_stocks", int'({stock500, stock200, stock100}), 24'h040404);
        tick();

        run_req(8, 0, 0, f5, f2, f1, c5, c2, c1, dc);
        chk("mix_first500", f5, 2); chk("mix_first200", f2, 5); chk("mix_first100", f1, 8);
        chk("mix_done", dc, 10); chk("mix_short", int'(short), 0); chk("mix_remain", int'(remain), 0);
        chk("mix_stocks", int'({stock500, stock200, stock100}), 24'h030303);

        run_req(30, 1, 0, f5, f2, f1, c5, c2, c1, dc);
        chk("r30_n500", c5, 4); chk("r30_n200", c2, 4); chk("r30_n100", c1, 2);
        chk("r30_short", int'(short), 0);
        chk("r30_stocks", int'({stock500, stock200, stock100}), 24'h000002);

        run_req(5, 0, 0, f5, f2, f1, c5, c2, c1, dc);
        chk("r5_n100", c1, 2); chk("r5_nother", c5 + c2, 0); chk("r5_done", dc, 8);
        chk("r5_short", int'(short), 1); chk("r5_remain", int'(remain), 3);
        chk("r5_stocks", int'({stock500, stock200, stock100}), 0);

        run_req(0, 0, 0, f5, f2, f1, c5, c2, c1, dc);
        chk("zero_done", dc, 1); chk("zero_pulses", c5 + c2 + c1, 0);

        refill = 1'b1; tick(); refill = 1'b0;
        chk("refill_idle", int'({stock500, stock200, stock100}), 24'h040404);

        run_req(3, 0, 2, f5, f2, f1, c5, c2, c1, dc);
        chk("refill_busy", int'({stock500, stock200, stock100}), 24'h040303);

        refill = 1'b1; tick(); refill = 1'b0;
        rq.req_valid = 1'b1; rq.req_amount = AMT_W'(2);
        @(posedge clk);
        c2 = 0; c5 = 0; c1 = 0; nd = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            c2 += int'(Out200); c5 += int'(Out500); c1 += int'(Out100); nd += int'(done);
            if (k == 2) rq.req_amount = AMT_W'(7);
            if (k == 4) rq.req_amount = AMT_W'(2);
            if (k == 10) rq.req_valid = 1'b0;
        end
        tick();
        chk("hs_n200", c2, 2); chk("hs_nother", c5 + c1, 0); chk("hs_ndone", nd, 2);

        rq.req_valid = 1'b1; rq.req_amount = AMT_W'(10); refill = 1'b1;
        tick();
        rq.req_valid = 1'b0; refill = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_pulse500", int'(Out500), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_stock500_pre", int'(stock500), 3);
        @(negedge clk);
        chk("mid_busy", int'(busy), 0);
        chk("mid_outs", int'({Out500, Out200, Out100, done}), 0);
        chk("mid_stocks", int'({stock500, stock200, stock100}), 24'h040404);
        @(posedge clk);
        #1 reset = 1'b1;
        nd = 0;
        repeat (8) begin @(negedge clk); nd += int'(done) + int'(Out500); end
        chk("mid_no_done", nd, 0);
        tick();

        for (int i = 0; i < 800; i++) begin
            rq.req_valid  = ($urandom_range(0, 2) == 0);
            rq.req_amount = AMT_W'($urandom_range(0, 20));
            refill        = ($urandom_range(0, 30) == 0);
            reset         = ($urandom_range(0, 200) != 0);
            tick();
        end
        rq.req_valid = 1'b0; refill = 1'b0; reset = 1'b1;
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/coin_payout.md
# coin_payout

Change-payout transmitter for the vending machine. It accepts a change amount through a valid/ready request, then drives the one-cycle coin pulses `Out500`, `Out200` and `Out100` using largest-coin-first selection. It keeps a per-denomination coin stock and reports completion, shortfall and undispensed remainder. It sits between the vending controller's change computation and the physical coin hoppers.

## Interface
- `AMT_W`, 8: width of the amount and remainder, in units of 100.
- `STOCK_W`, 8: width of each stock counter.
- `STOCK500` / `STOCK200` / `STOCK100`, 4 / 4 / 4: stock loaded at reset and on refill.
- `GAP`, 1: low cycles after each coin pulse (legal range ≥1).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- `req_valid`  in  1  change request present.
- `req_amount`  in  AMT_W  change to pay, in units of 100 (e.g. 7 = 700).
- `req_ready`  out  1  block can accept a request.
- `refill`  in  1  reload all stocks to parameter values.
- `Out500` / `Out200` / `Out100`  out  1  coin pulse, one cycle per coin.
- `busy`  out  1  request in progress.
- `done`  out  1  one-cycle completion strobe.
- `short`  out  1  last request not fully paid; held until the next acceptance.
- `remain`  out  AMT_W  undispensed units of the last request; held until the next acceptance.
- `stock500` / `stock200` / `stock100`  out  STOCK_W  current coin counts.

## Operation
- FSM states: IDLE, SELECT, PULSE, GAPW, DONE.
- **Reset** (`reset`=0 at an edge):
  - State goes to IDLE; `rem`, `coin` and `gapcnt` clear to 0.
  - Stocks load their parameter values.
  - All coin outputs, `busy`, `done`, `short` and `remain` go to 0.
  - `req_ready`=0 while `reset`=0.
- **IDLE:** `req_ready`=1 and `busy`=0.
  - On `req_valid`=1: latch `req_amount` into `rem`, clear `short` and `remain`.
  - If `req_amount`=0, go to DONE; otherwise go to SELECT.
- **SELECT:** choose the coin by the first rule that applies:
  - 500 if `rem`≥5 and `stock500`>0;
  - else 200 if `rem`≥2 and `stock200`>0;
  - else 100 if `rem`≥1 and `stock100`>0;
  - else go to DONE with `short`=1 and `remain`=`rem`.
  - When a coin is chosen, go to PULSE.
- **PULSE:** exactly one of `Out500`, `Out200`, `Out100` is high, matching the chosen coin.
  - At the exit edge, `rem` decreases by 5, 2 or 1 and the matching stock decreases by 1.
  - Go to GAPW.
- **GAPW:** stays GAP cycles with all coin outputs low.
  - Then go to DONE if `rem`=0, otherwise to SELECT.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
  - `short` and `remain` are valid in DONE and held afterwards.
- `busy`=1 in every state except IDLE.
- Coin outputs are Moore decodes of state and coin, with no combinational path from inputs.
- **Arithmetic:** `rem` never underflows, because subtraction happens only when `rem`≥value. Stocks never go below 0.
- **Refill:** honoured only in IDLE; stocks take the parameter values at that edge.
  - `refill` together with an accepted request: both take effect, and SELECT sees the refilled stock.
  - `refill` outside IDLE is ignored.
- `req_valid` outside IDLE is ignored; there is no queueing.
- Reset during any state aborts the request: no further coin pulse and no `done`.

## Timing
- Acceptance edge = cycle 0.
- First SELECT is cycle 1; first coin pulse is cycle 2.
- Each coin costs 2+GAP cycles.
- With n coins and no shortfall, `done` is high in cycle n·(2+GAP)+1.
- A shortfall found in SELECT puts DONE one cycle after that SELECT.
- A zero amount gives `done` in cycle 1 with no coin pulses.
- `req_ready` returns to 1 in the cycle after DONE. The earliest next acceptance is at the end of that cycle.
- Coin pulses are always separated by at least GAP+1 low cycles.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then release → all outputs 0, stocks 4/4/4; `req_ready`=1 from the first cycle after release.
- **Greedy mix:** GAP=1, full stock, request 8 → `Out500` at cycle 2, `Out200` at cycle 5, `Out100` at cycle 8; `done` at cycle 10; `short`=0, `remain`=0; stocks 3/3/3.
- **Stock fallback and shortfall:**
  - Request 30 → four 500, four 200, two 100; `short`=0; stocks 0/0/2.
  - Then request 5 → two 100 pulses; `short`=1, `remain`=3; stocks 0/0/0.
- **Zero and refill:**
  - Request 0 → `done` at cycle 1, no pulses.
  - Refill in IDLE → stocks 4/4/4.
  - Refill asserted while `busy`=1 → stocks unchanged.
- **Handshake:** hold `req_valid`=1 with amount 2 continuously → a single `Out200` per request, and requests are accepted only in IDLE. Change `req_amount` mid-request → no effect on the current request.
- **Mid-operation reset:** request 10, drop `reset` at cycle 3 → at the next edge, outputs are 0, no `done`, stocks 4/4/4.
